// File: rtl/div16_iter_if.sv
`default_nettype none
// ============================================================================
// Module      : div16_iter_if
// Description : Request/result bundle for the iterative divider.
// Revision    : 1.0 - initial release
// ============================================================================
interface div16_iter_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, signed_op, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, signed_op, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/div16_iter.sv
`default_nettype none
// ============================================================================
// Module      : div16_iter
// Description : Restoring divider, one quotient bit per cycle, signed/unsigned.
// Revision    : 1.0 - initial release
// ============================================================================
module div16_iter #(
    parameter int WIDTH = 16
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    div16_iter_if.slave      bus
);
    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_dmag;
    logic               r_q_neg;
    logic               r_r_neg;
    logic               r_dz;
    logic               r_done;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_div_by_zero;

    logic               w_accept;
    logic               w_dz_in;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_rem_s;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_step;
    logic [WIDTH-1:0]   w_q_step;

    assign w_accept = bus.start && (r_state != S_CALC);
    assign w_dz_in  = (bus.divisor == '0);
    assign w_a_neg  = bus.signed_op && bus.dividend[WIDTH-1];
    assign w_b_neg  = bus.signed_op && bus.divisor[WIDTH-1];
    assign w_a_mag  = w_a_neg ? (~bus.dividend + 1'b1) : bus.dividend;
    assign w_b_mag  = w_b_neg ? (~bus.divisor + 1'b1) : bus.divisor;

    // Partial remainder kept one bit wider so divisors above 2^(WIDTH-1) still divide correctly.
    assign w_rem_s    = {r_rem, r_q[WIDTH-1]};
    assign w_diff     = w_rem_s - {1'b0, r_dmag};
    assign w_ge       = ~w_diff[WIDTH];
    assign w_rem_step = w_ge ? w_diff[WIDTH-1:0] : w_rem_s[WIDTH-1:0];
    assign w_q_step   = {r_q[WIDTH-2:0], w_ge};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (bus.start) w_state_nxt = w_dz_in ? S_FIN : S_CALC;
            S_CALC: if (r_cnt == c_LAST) w_state_nxt = S_FIN;
            S_FIN:  w_state_nxt = bus.start ? (w_dz_in ? S_FIN : S_CALC) : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_rem         <= '0;
            r_q           <= '0;
            r_dmag        <= '0;
            r_q_neg       <= 1'b0;
            r_r_neg       <= 1'b0;
            r_dz          <= 1'b0;
            r_done        <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            if (w_accept) begin
                r_cnt   <= '0;
                r_rem   <= '0;
                // A zero divisor skips CALC, so r_q carries the raw dividend straight to FIN.
                r_q     <= w_dz_in ? bus.dividend : w_a_mag;
                r_dmag  <= w_b_mag;
                r_q_neg <= w_a_neg ^ w_b_neg;
                r_r_neg <= w_a_neg;
                r_dz    <= w_dz_in;
            end else if (r_state == S_CALC) begin
                r_cnt <= r_cnt + 1'b1;
                r_rem <= w_rem_step;
                r_q   <= w_q_step;
            end
            if (r_state == S_FIN) begin
                r_done        <= 1'b1;
                r_div_by_zero <= r_dz;
                if (r_dz) begin
                    r_quotient  <= '1;
                    r_remainder <= r_q;
                end else begin
                    r_quotient  <= r_q_neg ? (~r_q + 1'b1) : r_q;
                    r_remainder <= r_r_neg ? (~r_rem + 1'b1) : r_rem;
                end
            end
        end
    end

    assign bus.busy        = (r_state == S_CALC);
    assign bus.done        = r_done;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_div_by_zero;
endmodule
`default_nettype wire

// File: tb/tb_div16_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_div16_iter
// Description : Scoreboard bench for div16_iter with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div16_iter;
    typedef struct packed {
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic [31:0] cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    int   busy_cnt;
    int   ndone;
    exp_t sb[$];

    div16_iter_if #(.WIDTH(16)) bus ();

    div16_iter #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT reports a result.
    initial begin
        busy_cnt = 0;
        ndone    = 0;
        forever begin
            exp_t e;
            @(negedge clk);
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) begin
                ndone++;
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("quotient",    {16'd0, bus.quotient},  {16'd0, e.q});
                    check("remainder",   {16'd0, bus.remainder}, {16'd0, e.r});
                    check("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e.dz});
                    check("done_cycle",  cyc, e.cyc);
                end
            end
        end
    end

    // Called at a negedge; edge k is the next posedge. Returns at the negedge after edge k.
    task automatic issue(input logic s, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eq, input logic [15:0] er, input logic edz);
        exp_t e;
        e.q   = eq;
        e.r   = er;
        e.dz  = edz;
        e.cyc = cyc + 1 + (edz ? 1 : 17);
        sb.push_back(e);
        bus.start     = 1'b1;
        bus.signed_op = s;
        bus.dividend  = a;
        bus.divisor   = b;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int b0;
        int n0;
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",  {31'd0, bus.busy}, 32'd0);
        check("rst_done",  {31'd0, bus.done}, 32'd0);
        check("rst_quot",  {16'd0, bus.quotient}, 32'd0);
        check("rst_rem",   {16'd0, bus.remainder}, 32'd0);
        check("rst_dz",    {31'd0, bus.div_by_zero}, 32'd0);

        // First edge after release accepts the request.
        rst_n = 1'b1;
        b0 = busy_cnt;
        issue(1'b0, 16'd100, 16'd7, 16'h000E, 16'h0002, 1'b0);
        drain();
        check("busy_cycles_100_7", busy_cnt - b0, 32'd16);

        issue(1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0);
        drain();

        b0 = busy_cnt;
        issue(1'b0, 16'h04D2, 16'h0000, 16'hFFFF, 16'h04D2, 1'b1);
        drain();
        check("busy_cycles_dz", busy_cnt - b0, 32'd0);

        issue(1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0);
        drain();

        issue(1'b0, 16'd5, 16'd9, 16'h0000, 16'h0005, 1'b0);
        drain();
        issue(1'b1, 16'hFFFB, 16'h0009, 16'h0000, 16'hFFFB, 1'b0);
        drain();

        // Start pulsed during CALC cycle 5 must be ignored.
        n0 = ndone;
        issue(1'b0, 16'd1000, 16'd10, 16'd100, 16'd0, 1'b0);
        repeat (4) @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 16'd9;
        bus.divisor  = 16'd3;
        @(negedge clk);
        bus.start = 1'b0;
        drain();
        repeat (20) @(negedge clk);
        check("ignored_start_done_count", ndone - n0, 32'd1);

        // Reset in CALC cycle 8 aborts the operation.
        issue(1'b0, 16'd100, 16'd7, 16'h000E, 16'h0002, 1'b0);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_quot", {16'd0, bus.quotient}, 32'd0);
        check("abort_rem",  {16'd0, bus.remainder}, 32'd0);
        check("abort_dz",   {31'd0, bus.div_by_zero}, 32'd0);
        n0 = ndone;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check("abort_no_done", ndone - n0, 32'd0);

        // Accept on the very first edge after reset release.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(1'b0, 16'h1234, 16'h0034, 16'h0059, 16'h0020, 1'b0);
        drain();

        // Back-to-back: second start held in the FIN cycle of the first.
        issue(1'b0, 16'hFFFF, 16'h0010, 16'h0FFF, 16'h000F, 1'b0);
        repeat (16) @(negedge clk);
        issue(1'b1, 16'h0064, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
